pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register for the pipelined RISC-V core; next generation of the fixed-field stage registers between the IF/ID, ID/EX, EX/MEM and MEM/WB stages.
- Carries an opaque data bundle and a control bundle with a valid/ready handshake, an optional 1-entry skid buffer, flush-to-bubble, and a saturating stall counter.
- One instance per stage boundary, fields packed and unpacked by the parent CPU.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/sat_counter.sv | 33 +++
 rtl/pipe_stage_reg.sv | 107 ++++++++++
 tb/tb_pipe_stage_reg.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined RISC-V core: stage-register widths,
// control-bundle bit positions and the pipe_stage_reg occupancy encoding.
package cpu_pkg;

   localparam int IF_ID_DATA_W  = 64;
   localparam int IF_ID_CTRL_W  = 1;
   localparam int ID_EX_DATA_W  = 106;
   localparam int ID_EX_CTRL_W  = 7;
   localparam int EX_MEM_DATA_W = 71;
   localparam int EX_MEM_CTRL_W = 4;
   localparam int MEM_WB_DATA_W = 69;
   localparam int MEM_WB_CTRL_W = 2;

   // Control bundle layout; ALUOp occupies two bits starting at ALUOP_LSB.
   localparam int REGWRITE_B = 0;
   localparam int MEMTOREG_B = 1;
   localparam int MEMREAD_B  = 2;
   localparam int MEMWRITE_B = 3;
   localparam int ALUSRC_B   = 4;
   localparam int ALUOP_LSB  = 5;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] TWO   = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module sat_counter
   import cpu_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// flush-to-bubble and a saturating back-pressure counter.
module pipe_stage_reg
   import cpu_pkg::*;
#(
   parameter int DATA_W = ID_EX_DATA_W,
   parameter int CTRL_W = ID_EX_CTRL_W,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] mainData_q, mainData_d;
   logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d;
   logic [DATA_W-1:0] skidData_q, skidData_d;
   logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;
   logic              accept;
   logic              emit;

   // With the skid entry, ready depends only on occupancy, so ready_i never reaches ready_o.
   assign valid_o = (state_q != EMPTY);
   assign ready_o = (SKID != 0) ? (state_q != TWO) : (~valid_o | ready_i);
   assign accept  = valid_i & ready_o;
   assign emit    = valid_o & ready_i;
   assign data_o  = mainData_q;
   assign ctrl_o  = valid_o ? mainCtrl_q : '0;

   always_comb begin
      state_d    = state_q;
      mainData_d = mainData_q;
      mainCtrl_d = mainCtrl_q;
      skidData_d = skidData_q;
      skidCtrl_d = skidCtrl_q;
      if (flush_i) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d    = ONE;
                  mainData_d = data_i;
                  mainCtrl_d = ctrl_i;
               end
            end
            ONE: begin
               if (accept && emit) begin
                  mainData_d = data_i;
                  mainCtrl_d = ctrl_i;
               end else if (accept && (SKID != 0)) begin
                  state_d    = TWO;
                  skidData_d = data_i;
                  skidCtrl_d = ctrl_i;
               end else if (emit) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (emit) begin
                  state_d    = ONE;
                  mainData_d = skidData_q;
                  mainCtrl_d = skidCtrl_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= EMPTY;
         mainData_q <= '0;
         mainCtrl_q <= '0;
         skidData_q <= '0;
         skidCtrl_q <= '0;
      end else begin
         state_q    <= state_d;
         mainData_q <= mainData_d;
         mainCtrl_q <= mainCtrl_d;
         skidData_q <= skidData_d;
         skidCtrl_q <= skidCtrl_d;
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) stallCounter (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (valid_o & ~ready_i),
      .count_o(stall_cnt_o)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: skid instance, CNT_W=4 saturation
// instance and a SKID=0 instance, all driven from one clock.
module tb_pipe_stage_reg;
   import cpu_pkg::*;

   localparam int DW = ID_EX_DATA_W;
   localparam int CW = ID_EX_CTRL_W;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [CW-1:0] ctrl;
   } entry_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   entry_t expQ[$];
   entry_t exp0Q[$];
   entry_t monE;
   entry_t mon0E;
   logic monEn = 1'b0;

   logic          rst, flush, noFlush;
   logic [DW-1:0] dIn;
   logic [CW-1:0] cIn;

   logic          vIn, rdyIn, rdyO, vO;
   logic [DW-1:0] dO;
   logic [CW-1:0] cO;
   logic [15:0]   cnt;

   logic          sVin, sRdyIn, sRdyO, sVo;
   logic [DW-1:0] sDo;
   logic [CW-1:0] sCo;
   logic [3:0]    sCnt;

   logic          zVin, zRdyIn, zRdyO, zVo;
   logic [DW-1:0] zDo;
   logic [CW-1:0] zCo;
   logic [15:0]   zCnt;

   pipe_stage_reg dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vIn), .ready_o(rdyO),
      .data_i(dIn), .ctrl_i(cIn), .valid_o(vO), .ready_i(rdyIn),
      .data_o(dO), .ctrl_o(cO), .stall_cnt_o(cnt)
   );

   pipe_stage_reg #(.CNT_W(4)) dutSat (
      .clk_i(clk), .rst_i(rst), .flush_i(noFlush), .valid_i(sVin), .ready_o(sRdyO),
      .data_i(dIn), .ctrl_i(cIn), .valid_o(sVo), .ready_i(sRdyIn),
      .data_o(sDo), .ctrl_o(sCo), .stall_cnt_o(sCnt)
   );

   pipe_stage_reg #(.SKID(0)) dutNoSkid (
      .clk_i(clk), .rst_i(rst), .flush_i(noFlush), .valid_i(zVin), .ready_o(zRdyO),
      .data_i(dIn), .ctrl_i(cIn), .valid_o(zVo), .ready_i(zRdyIn),
      .data_o(zDo), .ctrl_o(zCo), .stall_cnt_o(zCnt)
   );

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                                input bit expectOut);
      vIn = v;
      dIn = d;
      cIn = c;
      if (expectOut) expQ.push_back({d, c});
      @(posedge clk);
      #1;
   endtask

   // Monitors sample mid-cycle; a handshake seen here completes at the next rising edge.
   always @(negedge clk) begin
      if (monEn) begin
         if (vO && rdyIn) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL main unexpected output: got data %0h, expected none", dO);
            end else begin
               monE = expQ.pop_front();
               checkOutput("main data", 128'(dO), 128'(monE.data));
               checkOutput("main ctrl", 128'(cO), 128'(monE.ctrl));
            end
         end else if (!vO) begin
            checkOutput("main bubble ctrl", 128'(cO), '0);
         end
      end
   end

   always @(negedge clk) begin
      if (monEn) begin
         if (zVo && zRdyIn) begin
            if (exp0Q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL noskid unexpected output: got data %0h, expected none", zDo);
            end else begin
               mon0E = exp0Q.pop_front();
               checkOutput("noskid data", 128'(zDo), 128'(mon0E.data));
               checkOutput("noskid ctrl", 128'(zCo), 128'(mon0E.ctrl));
            end
         end else if (!zVo) begin
            checkOutput("noskid bubble ctrl", 128'(zCo), '0);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; noFlush = 1'b0;
      vIn = 1'b1; rdyIn = 1'b1; dIn = 106'h3FF; cIn = 7'h7F;
      sVin = 1'b0; sRdyIn = 1'b1; zVin = 1'b0; zRdyIn = 1'b1;

      // Reset held two cycles while upstream presents a full control word
      @(posedge clk); #1;
      checkOutput("reset valid_o", 128'(vO), '0);
      checkOutput("reset ctrl_o", 128'(cO), '0);
      checkOutput("reset data_o", 128'(dO), '0);
      checkOutput("reset stall_cnt", 128'(cnt), '0);
      @(posedge clk); #1;
      rst = 1'b0;
      vIn = 1'b0;
      checkOutput("ready after reset", 128'(rdyO), 128'(1));
      checkOutput("valid after reset", 128'(vO), '0);
      monEn = 1'b1;

      // Streaming with ready_i high
      applyStimulus(1'b1, 106'h1, 7'h11, 1'b1);
      checkOutput("stream valid 1", 128'(vO), 128'(1));
      checkOutput("stream data 1", 128'(dO), 128'(1));
      applyStimulus(1'b1, 106'h2, 7'h22, 1'b1);
      checkOutput("stream data 2", 128'(dO), 128'(2));
      applyStimulus(1'b1, 106'h3, 7'h33, 1'b1);
      checkOutput("stream data 3", 128'(dO), 128'(3));
      checkOutput("stream valid 3", 128'(vO), 128'(1));
      applyStimulus(1'b0, 106'h0, 7'h00, 1'b0);
      checkOutput("stream drained", 128'(vO), '0);
      checkOutput("stream stall_cnt", 128'(cnt), '0);

      // Back-pressure fills the skid entry
      rdyIn = 1'b0;
      applyStimulus(1'b1, 106'hA, 7'h0A, 1'b1);
      applyStimulus(1'b1, 106'hB, 7'h0B, 1'b1);
      checkOutput("bp ready_o in TWO", 128'(rdyO), '0);
      checkOutput("bp data held A", 128'(dO), 128'(106'hA));
      checkOutput("bp stall_cnt 1", 128'(cnt), 128'(1));
      applyStimulus(1'b0, 106'h0, 7'h00, 1'b0);
      applyStimulus(1'b0, 106'h0, 7'h00, 1'b0);
      checkOutput("bp stall_cnt 3", 128'(cnt), 128'(3));
      checkOutput("bp still A", 128'(dO), 128'(106'hA));
      rdyIn = 1'b1;
      applyStimulus(1'b0, 106'h0, 7'h00, 1'b0);
      checkOutput("bp then B", 128'(dO), 128'(106'hB));
      checkOutput("bp ready back", 128'(rdyO), 128'(1));
      applyStimulus(1'b0, 106'h0, 7'h00, 1'b0);
      checkOutput("bp drained", 128'(vO), '0);
      checkOutput("bp stall_cnt kept", 128'(cnt), 128'(3));

      // Flush while TWO with C offered; D and E are squashed
      rdyIn = 1'b0;
      applyStimulus(1'b1, 106'hD, 7'h0D, 1'b1);
      applyStimulus(1'b1, 106'hE, 7'h0E, 1'b1);
      checkOutput("pre-flush stall_cnt", 128'(cnt), 128'(4));
      flush = 1'b1;
      applyStimulus(1'b1, 106'hC, 7'h0C, 1'b0);
      flush = 1'b0;
      expQ.delete();
      checkOutput("flush valid_o", 128'(vO), '0);
      checkOutput("flush ctrl_o", 128'(cO), '0);
      checkOutput("flush ready_o", 128'(rdyO), 128'(1));
      checkOutput("flush data held", 128'(dO), 128'(106'hD));
      checkOutput("flush stall_cnt", 128'(cnt), 128'(5));
      rdyIn = 1'b1;
      applyStimulus(1'b0, 106'h0, 7'h00, 1'b0);
      applyStimulus(1'b0, 106'h0, 7'h00, 1'b0);
      checkOutput("C never emitted", 128'(vO), '0);

      // Flush in ONE: pending F still emits, simultaneous G is discarded
      applyStimulus(1'b1, 106'hF, 7'h1F, 1'b1);
      flush = 1'b1;
      applyStimulus(1'b1, 106'h6, 7'h16, 1'b0);
      flush = 1'b0;
      vIn = 1'b0;
      checkOutput("flush1 valid_o", 128'(vO), '0);
      checkOutput("flush1 data held", 128'(dO), 128'(106'hF));
      applyStimulus(1'b0, 106'h0, 7'h00, 1'b0);
      applyStimulus(1'b0, 106'h0, 7'h00, 1'b0);
      checkOutput("main queue empty", 128'(expQ.size()), '0);

      // Saturation of a 4-bit stall counter
      sRdyIn = 1'b0;
      sVin = 1'b1;
      @(posedge clk); #1;
      sVin = 1'b0;
      checkOutput("sat valid", 128'(sVo), 128'(1));
      checkOutput("sat start", 128'(sCnt), '0);
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         checkOutput("sat count", 128'(sCnt), 128'((i < 15) ? i : 15));
      end

      // SKID=0: combinational ready, emit and accept together
      zRdyIn = 1'b0;
      zVin = 1'b1; dIn = 106'h55; cIn = 7'h55;
      exp0Q.push_back({106'h55, 7'h55});
      @(posedge clk); #1;
      zVin = 1'b0;
      checkOutput("noskid valid", 128'(zVo), 128'(1));
      checkOutput("noskid ready low", 128'(zRdyO), '0);
      zRdyIn = 1'b1;
      #1;
      checkOutput("noskid ready comb", 128'(zRdyO), 128'(1));
      zVin = 1'b1; dIn = 106'h66; cIn = 7'h66;
      exp0Q.push_back({106'h66, 7'h66});
      @(posedge clk); #1;
      zVin = 1'b0;
      checkOutput("noskid new valid", 128'(zVo), 128'(1));
      checkOutput("noskid new data", 128'(zDo), 128'(106'h66));
      @(posedge clk); #1;
      checkOutput("noskid drained", 128'(zVo), '0);
      checkOutput("noskid drained ctrl", 128'(zCo), '0);
      checkOutput("noskid queue empty", 128'(exp0Q.size()), '0);

      @(posedge clk); #1;
      monEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
